// File: rtl/spi_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_controller
// Description : One-byte command sequencer that streams SPI image bytes into
//               the BNN image buffer, clears it, and launches inference.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_controller #(
    parameter int IMG_BYTES      = 98,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int RESULT_W       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   spi_rx_data,
    input  logic                         byte_valid,
    output logic                         byte_taken,
    output logic                         rx_enable,
    output logic                         img_we,
    output logic [$clog2(IMG_BYTES)-1:0] img_addr,
    output logic [7:0]                   img_wdata,
    output logic                         infer_start,
    input  logic                         infer_done,
    input  logic [RESULT_W-1:0]          infer_result,
    output logic [RESULT_W-1:0]          result,
    output logic                         result_valid,
    output logic                         image_loaded,
    output logic                         busy,
    output logic                         error
);

    localparam int c_ADDR_W = $clog2(IMG_BYTES);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(IMG_BYTES - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] c_CMD_CLEAR = 8'h01;
    localparam logic [7:0] c_CMD_LOAD  = 8'h02;
    localparam logic [7:0] c_CMD_START = 8'h03;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_LOAD  = 2'd2;
    localparam logic [1:0] c_ST_INFER = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_ADDR_W-1:0] r_cnt;
    logic [c_TO_W-1:0]   r_idle_cnt;
    logic                r_take_block;
    logic                r_byte_taken;
    logic                r_wr_we;
    logic [c_ADDR_W-1:0] r_wr_addr;
    logic [7:0]          r_wr_data;
    logic                r_infer_d;
    logic                r_infer_start;
    logic [RESULT_W-1:0] r_result;
    logic                r_result_valid;
    logic                r_image_loaded;
    logic                r_error;

    logic w_accept;
    logic w_cmd_clear;
    logic w_cmd_load;
    logic w_cmd_bad;
    logic w_load_byte;
    logic w_load_last;
    logic w_timeout;
    logic w_done;

    // take_block hides the peripheral's still-high byte_valid right after a take
    assign w_accept = byte_valid && !r_take_block &&
                      ((r_state == c_ST_IDLE) || (r_state == c_ST_LOAD));

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_clear = 1'b0;
        w_cmd_load  = 1'b0;
        w_cmd_bad   = 1'b0;
        w_load_byte = 1'b0;
        w_load_last = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    case (spi_rx_data)
                        c_CMD_CLEAR: begin
                            w_cmd_clear = 1'b1;
                            w_state_nxt = c_ST_CLEAR;
                        end
                        c_CMD_LOAD: begin
                            w_cmd_load  = 1'b1;
                            w_state_nxt = c_ST_LOAD;
                        end
                        c_CMD_START: begin
                            if (r_image_loaded) begin
                                w_state_nxt = c_ST_INFER;
                            end else begin
                                w_cmd_bad = 1'b1;
                            end
                        end
                        default: w_cmd_bad = 1'b1;
                    endcase
                end
            end
            c_ST_CLEAR: begin
                if (r_cnt == c_LAST_ADDR) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_LOAD: begin
                if (w_accept) begin
                    w_load_byte = 1'b1;
                    if (r_cnt == c_LAST_ADDR) begin
                        w_load_last = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (r_idle_cnt == c_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_INFER: begin
                // A done level left over from before the launch pulse is not trusted
                if (infer_done && r_infer_d && !r_infer_start) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_idle_cnt     <= '0;
            r_take_block   <= 1'b0;
            r_byte_taken   <= 1'b0;
            r_wr_we        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_infer_d      <= 1'b0;
            r_infer_start  <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_image_loaded <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_byte_taken  <= w_accept;
            r_wr_we       <= w_load_byte;
            r_infer_d     <= (r_state == c_ST_INFER);
            r_infer_start <= (r_state == c_ST_INFER) && !r_infer_d;

            if (w_accept) begin
                r_take_block <= 1'b1;
            end else if (!byte_valid) begin
                r_take_block <= 1'b0;
            end

            if (w_load_byte) begin
                r_wr_addr <= r_cnt;
                r_wr_data <= spi_rx_data;
            end

            // Shared address counter for CLEAR sweeps and LOAD writes, saturating
            if (w_cmd_clear || w_cmd_load) begin
                r_cnt <= '0;
            end else if (((r_state == c_ST_CLEAR) || w_load_byte) && (r_cnt != c_LAST_ADDR)) begin
                r_cnt <= r_cnt + c_ADDR_W'(1);
            end

            if ((r_state != c_ST_LOAD) || w_accept) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
            end

            if (w_cmd_clear) begin
                r_error <= 1'b0;
            end else if (w_cmd_bad || w_timeout) begin
                r_error <= 1'b1;
            end

            if (w_cmd_clear || w_cmd_load) begin
                r_image_loaded <= 1'b0;
            end else if (w_load_last) begin
                r_image_loaded <= 1'b1;
            end

            if (w_cmd_clear || w_cmd_load) begin
                r_result_valid <= 1'b0;
            end else if (w_done) begin
                r_result_valid <= 1'b1;
            end

            if (w_done) begin
                r_result <= infer_result;
            end
        end
    end

    assign byte_taken   = r_byte_taken;
    assign rx_enable    = (r_state == c_ST_IDLE) || (r_state == c_ST_LOAD);
    assign busy         = (r_state != c_ST_IDLE);
    assign img_we       = (r_state == c_ST_CLEAR) || r_wr_we;
    assign img_addr     = (r_state == c_ST_CLEAR) ? r_cnt : r_wr_addr;
    assign img_wdata    = (r_state == c_ST_CLEAR) ? 8'h00 : r_wr_data;
    assign infer_start  = r_infer_start;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign image_loaded = r_image_loaded;
    assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_controller
// Description : Scoreboard bench for spi_cmd_controller command sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_controller;

    localparam int IMG = 98;
    localparam int TO  = 300;
    localparam int RW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    spi_rx_data = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_taken;
    logic          rx_enable;
    logic          img_we;
    logic [6:0]    img_addr;
    logic [7:0]    img_wdata;
    logic          infer_start;
    logic          infer_done = 1'b0;
    logic [RW-1:0] infer_result = '0;
    logic [RW-1:0] result;
    logic          result_valid;
    logic          image_loaded;
    logic          busy;
    logic          error;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [RW-1:0] res_q[$];
    wr_t           mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int taken_cnt = 0;
    int start_cnt = 0;
    int we_run = 0;
    int last_run = 0;
    int taken_cyc = 0;
    int start_cyc = 0;
    logic rv_prev = 1'b0;

    spi_cmd_controller #(
        .IMG_BYTES      (IMG),
        .TIMEOUT_CYCLES (TO),
        .RESULT_W       (RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_rx_data  (spi_rx_data),
        .byte_valid   (byte_valid),
        .byte_taken   (byte_taken),
        .rx_enable    (rx_enable),
        .img_we       (img_we),
        .img_addr     (img_addr),
        .img_wdata    (img_wdata),
        .infer_start  (infer_start),
        .infer_done   (infer_done),
        .infer_result (infer_result),
        .result       (result),
        .result_valid (result_valid),
        .image_loaded (image_loaded),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard queues as the DUT produces writes/results
    always @(negedge clk) begin
        if (!rst) begin
            if (img_we) begin
                if (exp_q.size() == 0) begin
                    chk("wr_q_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(img_addr), 32'(mon_e.addr));
                    chk("wr_data", 32'(img_wdata), 32'(mon_e.data));
                end
                we_run++;
            end else begin
                if (we_run != 0) last_run = we_run;
                we_run = 0;
            end
            if (byte_taken) begin
                taken_cnt++;
                taken_cyc = cyc;
            end
            if (infer_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (result_valid && !rv_prev) begin
                if (res_q.size() == 0) begin
                    chk("res_q_nonempty", 32'(res_q.size()), 32'd1);
                end else begin
                    chk("result", 32'(result), 32'(res_q.pop_front()));
                end
            end
        end
        rv_prev = result_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        spi_rx_data = b;
        byte_valid  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i;
        i = 0;
        while (busy && (i < budget)) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic load_image(input bit inv);
        logic [7:0] d;
        send_byte(8'h02);
        for (int i = 0; i < IMG; i++) begin
            d = inv ? 8'(255 - i) : 8'(i);
            exp_q.push_back({7'(i), d});
            send_byte(d);
        end
        wait_idle("load_idle", 50);
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, 32'({byte_taken, rx_enable, img_we, infer_start,
                      result_valid, image_loaded, busy, error}), 32'h40);
        chk({tag, "_data"}, 32'({img_addr, img_wdata, result}), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int s0;
        int rx_hi;
        int el;

        // Reset state, during and just after reset
        tick(3);
        @(negedge clk);
        chk_reset("reset_held");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset("reset_rel");

        // START without an image
        s0 = start_cnt;
        send_byte(8'h03);
        tick(3);
        chk("start_noimg_err", 32'(error), 32'd1);
        chk("start_noimg_busy", 32'(busy), 32'd0);
        chk("start_noimg_nostart", 32'(start_cnt - s0), 32'd0);

        // CLEAR: 98 consecutive zero writes, error cleared
        for (int i = 0; i < IMG; i++) exp_q.push_back({7'(i), 8'h00});
        send_byte(8'h01);
        chk("clear_rx_en", 32'(rx_enable), 32'd0);
        wait_idle("clear_idle", 200);
        tick(2);
        chk("clear_err", 32'(error), 32'd0);
        chk("clear_run", 32'(last_run), 32'(IMG));
        chk("clear_q_empty", 32'(exp_q.size()), 32'd0);

        // Full image load
        t0 = taken_cnt;
        load_image(1'b0);
        tick(2);
        chk("load_loaded", 32'(image_loaded), 32'd1);
        chk("load_taken", 32'(taken_cnt - t0), 32'(IMG + 1));
        chk("load_q_empty", 32'(exp_q.size()), 32'd0);
        chk("load_rx_en", 32'(rx_enable), 32'd1);

        // Inference
        s0 = start_cnt;
        send_byte(8'h03);
        rx_hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (rx_enable) rx_hi++;
        end
        chk("infer_rx_low", 32'(rx_hi), 32'd0);
        chk("infer_busy", 32'(busy), 32'd1);
        chk("infer_start_cnt", 32'(start_cnt - s0), 32'd1);
        chk("infer_start_lat", 32'(start_cyc - taken_cyc), 32'd1);
        @(posedge clk);
        #1;
        infer_done   = 1'b1;
        infer_result = 4'd7;
        res_q.push_back(4'd7);
        @(posedge clk);
        #1;
        infer_done   = 1'b0;
        infer_result = '0;
        @(negedge clk);
        chk("infer_rv", 32'(result_valid), 32'd1);
        chk("infer_rx_back", 32'(rx_enable), 32'd1);
        chk("infer_idle", 32'(busy), 32'd0);
        tick(1);
        chk("res_q_empty", 32'(res_q.size()), 32'd0);

        // Unknown command
        t0 = taken_cnt;
        send_byte(8'hAA);
        tick(3);
        chk("bad_taken", 32'(taken_cnt - t0), 32'd1);
        chk("bad_err", 32'(error), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_keep", 32'({image_loaded, result_valid}), 32'h3);

        // CLEAR then LOAD timeout after 10 bytes
        for (int i = 0; i < IMG; i++) exp_q.push_back({7'(i), 8'h00});
        send_byte(8'h01);
        wait_idle("clear2_idle", 200);
        tick(1);
        chk("clear2_state", 32'({error, image_loaded, result_valid}), 32'd0);
        send_byte(8'h02);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({7'(i), 8'(8'h30 + i)});
            send_byte(8'(8'h30 + i));
        end
        el = 0;
        while (busy && (el < TO + 50)) begin
            @(negedge clk);
            el++;
        end
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_window", 32'((el >= TO - 1) && (el <= TO + 1)), 32'd1);
        chk("to_err", 32'(error), 32'd1);
        chk("to_loaded", 32'(image_loaded), 32'd0);
        chk("to_rx_en", 32'(rx_enable), 32'd1);
        chk("to_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a load, then a clean reload
        send_byte(8'h02);
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back({7'(i), 8'(8'h80 + i)});
            send_byte(8'(8'h80 + i));
        end
        chk("mid_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset("mid_reset");
        tick(2);
        rst = 1'b0;
        chk("mid_q_empty", 32'(exp_q.size()), 32'd0);
        t0 = taken_cnt;
        load_image(1'b1);
        tick(2);
        chk("reload_loaded", 32'(image_loaded), 32'd1);
        chk("reload_err", 32'(error), 32'd0);
        chk("reload_taken", 32'(taken_cnt - t0), 32'(IMG + 1));
        chk("reload_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_cmd_controller.md
Name: spi_cmd_controller

Overview:
- Command sequencer between spi_peripheral and the BNN image buffer / inference core.
- Drains received bytes through the byte_valid/byte_taken handshake, decodes a one-byte command protocol, and streams image bytes into the image buffer.
- Clears the buffer on command, launches inference and latches the result.
- Owns rx_enable, so reception is paused while inference runs.

Parameters:
- IMG_BYTES, 98, packed image size in bytes (28x28 bits, MSB-first per byte).
- TIMEOUT_CYCLES, 100000, maximum idle clk cycles between image bytes during LOAD.
- RESULT_W, 4, width of the inference class result.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- spi_rx_data  in  8  received byte from spi_peripheral
- byte_valid  in  1  byte available from spi_peripheral
- byte_taken  out  1  one-cycle consume pulse to spi_peripheral
- rx_enable  out  1  enables spi_peripheral reception
- img_we  out  1  image buffer write strobe
- img_addr  out  $clog2(IMG_BYTES)  image buffer byte address
- img_wdata  out  8  image buffer write data
- infer_start  out  1  one-cycle inference launch pulse
- infer_done  in  1  inference complete, held for at least one cycle
- infer_result  in  RESULT_W  class index, valid while infer_done=1
- result  out  RESULT_W  latched class index
- result_valid  out  1  result holds a fresh inference
- image_loaded  out  1  full image present in the buffer
- busy  out  1  not in IDLE
- error  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, rst=1) sets every output to 0, except rx_enable=1. State=IDLE, byte counter=0, take_block=0.
- Byte acceptance:
  - A byte is accepted in the cycle where byte_valid=1 and take_block=0 and the state accepts bytes (IDLE or LOAD).
  - byte_taken is asserted combinationally-free: it is registered and pulses for exactly one cycle, the cycle after acceptance.
  - take_block sets with byte_taken and clears in the first cycle byte_valid=0 is sampled. This prevents double-consuming the peripheral's registered byte_valid.
- Commands decoded in IDLE, consumed on acceptance:
  - 0x01 CLEAR: go to CLEAR. Clear image_loaded, result_valid and error.
  - 0x02 LOAD: go to LOAD. Counter=0, clear image_loaded and result_valid.
  - 0x03 START: if image_loaded=1, go to INFER. Otherwise set error and stay IDLE.
  - Any other value: set error, stay IDLE. The byte is still consumed.
- CLEAR:
  - Writes 0x00 to addresses 0..IMG_BYTES-1, one per cycle: img_we=1 for IMG_BYTES consecutive cycles.
  - rx_enable=0 throughout.
  - Returns to IDLE the cycle after the last write.
- LOAD:
  - Each accepted byte drives img_we=1, img_addr=counter, img_wdata=byte in the cycle after acceptance, aligned with byte_taken. Counter then increments.
  - After the write at address IMG_BYTES-1: set image_loaded, return to IDLE.
  - The counter saturates and never wraps.
  - The timeout counter resets on each acceptance. On reaching TIMEOUT_CYCLES: set error, leave image_loaded=0, return to IDLE.
- INFER:
  - rx_enable drops to 0 on entry; infer_start pulses one cycle on entry.
  - Waits for infer_done. Then result<=infer_result, result_valid=1, return to IDLE, rx_enable=1.
  - infer_done sampled in any state other than INFER is ignored.
- rx_enable=1 only in IDLE and LOAD. busy=1 in CLEAR, LOAD and INFER.
- error is sticky and cleared only by CLEAR or reset. Commands other than CLEAR are still processed while error=1.
- Reset mid-LOAD, mid-CLEAR or mid-INFER returns to IDLE immediately. Partial buffer contents are left as-is and image_loaded=0.
- Latency:
  - Command accept to state entry: 1 cycle.
  - START accept to infer_start: 2 cycles.
  - infer_done to result_valid: 1 cycle.

Test Plan:
- Send 0x02 then 98 bytes 0x00..0x61 with byte_valid held 2 cycles each -> exactly 98 img_we pulses, addresses 0..97 with data equal to address, image_loaded=1, one byte_taken per byte.
- Send 0x03 with image_loaded=0 -> error=1, infer_start never pulses, state IDLE. Then send 0x01 -> error=0 and 98 zero writes on consecutive cycles.
- Load a full image, send 0x03, drive infer_done=1 with infer_result=7 after 50 cycles -> infer_start one pulse, rx_enable=0 during wait, result=7, result_valid=1, rx_enable=1.
- Send 0x02, 10 bytes, then stall TIMEOUT_CYCLES -> error=1, image_loaded=0, IDLE, rx_enable=1.
- Send command 0xAA -> byte consumed (single byte_taken), error=1, no state change.
- Assert rst during LOAD at byte 40 -> all outputs reset values, rx_enable=1. A following full load completes normally.
